wbu_chanmux: RTL and testbench
==============================

WBU_CHANMUX -- requirements
Module: wbu_chanmux

Interface
REQ-001 SHALL have parameter NCHAN, default 4, number of 7-bit console channels; legal range 1..8.
REQ-002 SHALL have parameter ESC, default 7'h10, console escape code (DLE).
REQ-003 SHALL have parameter SEL0, default 7'h30, channel-select base code ('0').
REQ-004 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_rx_stb / i_rx_data  in  1 / 8  received link byte strobe and data.
REQ-007 SHALL have port o_wbu_rx_stb / o_wbu_rx_data  out  1 / 7  bus-command byte to wbuinput.
REQ-008 SHALL have port i_wbu_tx_stb / i_wbu_tx_data  in  1 / 7  bus-response byte from wbuoutput.
REQ-009 SHALL have port o_wbu_tx_busy  out  1  back-pressure to wbuoutput.
REQ-010 SHALL have port i_con_stb / i_con_data  in  NCHAN / 7*NCHAN  console TX requests; channel k data in bits [7k+6:7k].
REQ-011 SHALL have port o_con_busy  out  NCHAN  per-channel back-pressure.
REQ-012 SHALL have port o_con_stb / o_con_data  out  NCHAN / 7  one-hot console RX strobe, shared data.
REQ-013 SHALL have port o_tx_stb / o_tx_data / i_tx_busy  out / out / in  1 / 8 / 1  link TX handshake.
REQ-014 SHALL have port o_rx_err  out  1  one-cycle pulse on malformed escape.

Function
REQ-015 Link byte bit7=1 SHALL be bus traffic; bit7=0 SHALL be console traffic on the current channel.
REQ-016 Console escapes: ESC,ESC = literal ESC data; ESC,(SEL0+k), k<NCHAN = switch current channel to k.
REQ-017 RX: bit7=1 byte SHALL produce o_wbu_rx_stb with data[6:0] one cycle later; RX escape state unaffected.
REQ-018 RX FSM states IDLE, ESCD; IDLE: ESC -> ESCD, no output; other bit7=0 byte -> o_con_stb[rx_chan] with data, one cycle later.
REQ-019 ESCD: ESC -> emit literal ESC on rx_chan, IDLE; SEL0+k (k<NCHAN) -> rx_chan<=k, IDLE; anything else -> drop byte, o_rx_err pulse, IDLE.
REQ-020 TX output register: o_tx_stb held with stable o_tx_data until cycle where i_tx_busy=0, then cleared or reloaded.
REQ-021 Load slot free = (!o_tx_stb || !i_tx_busy) && tx FSM in IDLE.
REQ-022 TX FSM states IDLE, SELA (send ESC), SELB (send SEL0+chan), DATA (send held byte), LIT (send second ESC).
REQ-023 WBU priority: in IDLE with slot free, i_wbu_tx_stb SHALL load {1'b1,data}; o_wbu_tx_busy = !slot-free.
REQ-024 Console grant: current tx_chan if its stb is set, else first requesting channel round-robin after tx_chan; evaluated only when slot free and no WBU request.
REQ-025 o_con_busy[k] SHALL be 0 only for the granted k under REQ-024; acceptance = i_con_stb[k] && !o_con_busy[k].
REQ-026 Accepted byte, k==tx_chan: non-ESC loads {0,data} directly; ESC loads ESC, FSM -> LIT.
REQ-027 Accepted byte, k!=tx_chan: byte held, tx_chan<=k, load ESC, FSM SELB, then DATA (or ESC then LIT if byte==ESC), then IDLE.
REQ-028 An escape sequence SHALL NOT be split by WBU bytes; WBU waits until IDLE.
REQ-029 NCHAN=1: channel-select codes never generated; received select k=0 accepted.

Reset
REQ-030 On i_reset: all stb outputs 0, o_con_busy all 1 until first edge after release, o_rx_err 0, both FSMs IDLE, tx_chan=rx_chan=0, held data dropped.
REQ-031 Reset mid-sequence SHALL abandon the sequence; link peer resynchronises at channel 0.

Verification
REQ-032 NCHAN=4, rx 0x10,0x32,0x41 -> rx_chan=2, o_con_stb=4'b0100, data 7'h41, one cycle after third byte.
REQ-033 rx 0x10,0x10 -> o_con_stb[0] with 7'h10; rx 0x10,0x39 -> o_rx_err pulse, no con strobe.
REQ-034 After reset, ch1 sends 0x55 -> link bytes 0x10,0x31,0x55 in order; second 0x55 on ch1 -> single 0x55.
REQ-035 WBU 0x23 and ch0 0x41 same cycle, i_tx_busy=0 -> 0xA3 then 0x41; during ch3 select sequence WBU held busy until DATA sent.
REQ-036 ch0 and ch2 continuously requesting, tx_chan=0 -> ch0 keeps grant; ch0 drops -> switch to ch2 via 0x10,0x32; i_tx_busy=1 for 5 cycles -> o_tx_data stable.

Source files
------------

// File: rtl/wbu_chanmux.sv
// wbu_chanmux: multiplexes a bus-command stream and NCHAN 7-bit consoles over one 8-bit link.
// Ports: i_clk/i_reset clock and async reset; i_rx_* link receive; o_wbu_rx_* bus commands out;
// i_wbu_tx_*/o_wbu_tx_busy bus responses in; i_con_*/o_con_busy console TX requests;
// o_con_stb/o_con_data console RX; o_tx_*/i_tx_busy link transmit; o_rx_err malformed escape.
module wbu_chanmux #(
    parameter int         NCHAN = 4,
    parameter logic [6:0] ESC   = 7'h10,
    parameter logic [6:0] SEL0  = 7'h30
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_stb,
    input  logic [7:0]           i_rx_data,
    output logic                 o_wbu_rx_stb,
    output logic [6:0]           o_wbu_rx_data,
    input  logic                 i_wbu_tx_stb,
    input  logic [6:0]           i_wbu_tx_data,
    output logic                 o_wbu_tx_busy,
    input  logic [NCHAN-1:0]     i_con_stb,
    input  logic [7*NCHAN-1:0]   i_con_data,
    output logic [NCHAN-1:0]     o_con_busy,
    output logic [NCHAN-1:0]     o_con_stb,
    output logic [6:0]           o_con_data,
    output logic                 o_tx_stb,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic                 o_rx_err
);
    localparam int         CW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [7:0] NC8 = 8'(NCHAN);

    typedef enum logic {RX_IDLE, RX_ESCD} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_SELA, TX_SELB, TX_DATA, TX_LIT} tx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CW-1:0]    rx_chan_q, rx_chan_d;
    logic [NCHAN-1:0] con_stb_q, con_stb_d;
    logic [6:0]       con_data_q, con_data_d;
    logic             rx_err_q, rx_err_d;
    logic             wbu_rx_stb_q;
    logic [6:0]       wbu_rx_data_q;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CW-1:0]    tx_chan_q, tx_chan_d;
    logic [6:0]       held_q, held_d;
    logic             tx_stb_q, tx_stb_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rdy_q;

    logic [6:0]       cdat, sel_k;
    logic             sel_ok, can_load, slot_free, gnt_ok;
    logic [CW-1:0]    gnt;
    logic [6:0]       gdat;

    assign cdat   = i_rx_data[6:0];
    assign sel_k  = cdat - SEL0;
    assign sel_ok = (cdat >= SEL0) && ({1'b0, sel_k} < NC8);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_chan_d  = rx_chan_q;
        con_stb_d  = '0;
        con_data_d = con_data_q;
        rx_err_d   = 1'b0;
        if (i_rx_stb && !i_rx_data[7]) begin
            if (rx_state_q == RX_IDLE) begin
                if (cdat == ESC) rx_state_d = RX_ESCD;
                else begin
                    con_stb_d  = NCHAN'(1) << rx_chan_q;
                    con_data_d = cdat;
                end
            end else begin
                rx_state_d = RX_IDLE;
                if (cdat == ESC) begin
                    con_stb_d  = NCHAN'(1) << rx_chan_q;
                    con_data_d = ESC;
                end else if (sel_ok) rx_chan_d = sel_k[CW-1:0];
                else rx_err_d = 1'b1;
            end
        end
    end

    assign can_load  = !tx_stb_q || !i_tx_busy;
    assign slot_free = can_load && (tx_state_q == TX_IDLE);

    // Round-robin search runs from the farthest channel inward so the nearest
    // requester after tx_chan wins; the current channel overrides everything.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = '0;
        gdat   = '0;
        for (int i = NCHAN - 1; i >= 1; i--) begin
            if (i_con_stb[CW'((int'(tx_chan_q) + i) % NCHAN)]) begin
                gnt_ok = 1'b1;
                gnt    = CW'((int'(tx_chan_q) + i) % NCHAN);
            end
        end
        if (i_con_stb[tx_chan_q]) begin
            gnt_ok = 1'b1;
            gnt    = tx_chan_q;
        end
        gnt_ok = gnt_ok && slot_free && !i_wbu_tx_stb && rdy_q;
        for (int k = 0; k < NCHAN; k++)
            if (CW'(k) == gnt) gdat = i_con_data[7*k +: 7];
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_chan_d  = tx_chan_q;
        held_d     = held_q;
        tx_stb_d   = tx_stb_q;
        tx_data_d  = tx_data_q;
        if (can_load) begin
            tx_stb_d = 1'b1;
            case (tx_state_q)
                TX_IDLE: begin
                    if (i_wbu_tx_stb) tx_data_d = {1'b1, i_wbu_tx_data};
                    else if (gnt_ok && gnt == tx_chan_q) begin
                        tx_data_d  = {1'b0, gdat};
                        tx_state_d = (gdat == ESC) ? TX_LIT : TX_IDLE;
                    end else if (gnt_ok) begin
                        tx_data_d  = {1'b0, ESC};
                        held_d     = gdat;
                        tx_chan_d  = gnt;
                        tx_state_d = TX_SELB;
                    end else tx_stb_d = 1'b0;
                end
                TX_SELA: begin
                    tx_data_d  = {1'b0, ESC};
                    tx_state_d = TX_SELB;
                end
                TX_SELB: begin
                    tx_data_d  = {1'b0, SEL0 + 7'(tx_chan_q)};
                    tx_state_d = TX_DATA;
                end
                TX_DATA: begin
                    tx_data_d  = {1'b0, held_q};
                    tx_state_d = (held_q == ESC) ? TX_LIT : TX_IDLE;
                end
                TX_LIT: begin
                    tx_data_d  = {1'b0, ESC};
                    tx_state_d = TX_IDLE;
                end
                default: begin
                    tx_stb_d   = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_state_q    <= RX_IDLE;
            rx_chan_q     <= '0;
            con_stb_q     <= '0;
            con_data_q    <= '0;
            rx_err_q      <= 1'b0;
            wbu_rx_stb_q  <= 1'b0;
            wbu_rx_data_q <= '0;
            tx_state_q    <= TX_IDLE;
            tx_chan_q     <= '0;
            held_q        <= '0;
            tx_stb_q      <= 1'b0;
            tx_data_q     <= '0;
            rdy_q         <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_chan_q     <= rx_chan_d;
            con_stb_q     <= con_stb_d;
            con_data_q    <= con_data_d;
            rx_err_q      <= rx_err_d;
            wbu_rx_stb_q  <= i_rx_stb && i_rx_data[7];
            wbu_rx_data_q <= (i_rx_stb && i_rx_data[7]) ? cdat : wbu_rx_data_q;
            tx_state_q    <= tx_state_d;
            tx_chan_q     <= tx_chan_d;
            held_q        <= held_d;
            tx_stb_q      <= tx_stb_d;
            tx_data_q     <= tx_data_d;
            rdy_q         <= 1'b1;
        end
    end

    assign o_wbu_rx_stb  = wbu_rx_stb_q;
    assign o_wbu_rx_data = wbu_rx_data_q;
    assign o_con_stb     = con_stb_q;
    assign o_con_data    = con_data_q;
    assign o_rx_err      = rx_err_q;
    assign o_tx_stb      = tx_stb_q;
    assign o_tx_data     = tx_data_q;
    assign o_wbu_tx_busy = !slot_free;
    assign o_con_busy    = ~(gnt_ok ? NCHAN'(1) << gnt : '0);
endmodule

// File: tb/tb_wbu_chanmux.sv
// tb_wbu_chanmux: directed checks of link RX demux and TX escape/arbitration for wbu_chanmux.
module tb_wbu_chanmux;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        wbu_rx_stb;
    logic [6:0]  wbu_rx_data;
    logic        wbu_tx_stb = 1'b0;
    logic [6:0]  wbu_tx_data = '0;
    logic        wbu_tx_busy;
    logic [3:0]  con_stb = '0;
    logic [27:0] con_data = '0;
    logic [3:0]  con_busy;
    logic [3:0]  con_rx_stb;
    logic [6:0]  con_rx_data;
    logic        tx_stb;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] lq[$];
    logic [7:0] eq[$];

    wbu_chanmux dut (
        .i_clk(clk), .i_reset(rst),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_wbu_rx_stb(wbu_rx_stb), .o_wbu_rx_data(wbu_rx_data),
        .i_wbu_tx_stb(wbu_tx_stb), .i_wbu_tx_data(wbu_tx_data), .o_wbu_tx_busy(wbu_tx_busy),
        .i_con_stb(con_stb), .i_con_data(con_data), .o_con_busy(con_busy),
        .o_con_stb(con_rx_stb), .o_con_data(con_rx_data),
        .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
        .o_rx_err(rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (!rst && tx_stb && !tx_busy) lq.push_back(tx_data);
    end

    typedef struct {
        logic [7:0] b;
        logic [3:0] cs;
        logic [6:0] cd;
        logic       ws;
        logic [6:0] wd;
        logic       err;
    } rxv_t;
    rxv_t v[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm);
        chk({nm, "_len"}, lq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i < lq.size()) chk($sformatf("%s_b%0d", nm, i), {24'h0, lq[i]}, {24'h0, eq[i]});
        lq.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        rx_stb = 1'b0; wbu_tx_stb = 1'b0; con_stb = '0; tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset", {con_busy, tx_stb, con_rx_stb, rx_err, wbu_rx_stb}, {4'hF, 1'b0, 4'h0, 1'b0, 1'b0});
        rst = 1'b0;
        @(negedge clk);
        lq.delete();
    endtask

    task automatic con_send(input int k, input logic [6:0] d);
        logic ok;
        ok = 1'b0;
        con_stb[k] = 1'b1;
        con_data[7*k +: 7] = d;
        for (int n = 0; n < 40 && !ok; n++) begin
            #1;
            if (!con_busy[k]) ok = 1'b1;
            @(negedge clk);
        end
        con_stb[k] = 1'b0;
        chk($sformatf("accept_ch%0d", k), {31'h0, ok}, 32'h1);
    endtask

    initial begin
        v[0]  = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[1]  = '{8'h32, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[2]  = '{8'h41, 4'h4, 7'h41, 1'b0, 7'h00, 1'b0};
        v[3]  = '{8'hC5, 4'h0, 7'h00, 1'b1, 7'h45, 1'b0};
        v[4]  = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[5]  = '{8'h85, 4'h0, 7'h00, 1'b1, 7'h05, 1'b0};
        v[6]  = '{8'h10, 4'h4, 7'h10, 1'b0, 7'h00, 1'b0};
        v[7]  = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[8]  = '{8'h39, 4'h0, 7'h00, 1'b0, 7'h00, 1'b1};
        v[9]  = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[10] = '{8'h34, 4'h0, 7'h00, 1'b0, 7'h00, 1'b1};
        v[11] = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[12] = '{8'h30, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[13] = '{8'h7F, 4'h1, 7'h7F, 1'b0, 7'h00, 1'b0};
        v[14] = '{8'h10, 4'h0, 7'h00, 1'b0, 7'h00, 1'b0};
        v[15] = '{8'h10, 4'h1, 7'h10, 1'b0, 7'h00, 1'b0};

        #1;
        reset_dut();

        for (int i = 0; i < 16; i++) begin
            rx_stb = 1'b1;
            rx_data = v[i].b;
            @(negedge clk);
            chk($sformatf("rx_vec%0d", i),
                {12'h0, con_rx_stb, (con_rx_stb != 0) ? con_rx_data : 7'h0,
                 wbu_rx_stb, wbu_rx_stb ? wbu_rx_data : 7'h0, rx_err},
                {12'h0, v[i].cs, v[i].cd, v[i].ws, v[i].wd, v[i].err});
        end
        rx_stb = 1'b0;
        @(negedge clk);
        chk("rx_quiet", {con_rx_stb, wbu_rx_stb, rx_err}, 6'h0);

        reset_dut();
        con_send(1, 7'h55);
        con_send(1, 7'h55);
        repeat (4) @(negedge clk);
        eq = '{8'h10, 8'h31, 8'h55, 8'h55};
        chk_q("sel_ch1");

        reset_dut();
        wbu_tx_stb = 1'b1; wbu_tx_data = 7'h23;
        con_stb[0] = 1'b1; con_data[6:0] = 7'h41;
        #1;
        chk("wbu_first_busy", {31'h0, wbu_tx_busy}, 32'h0);
        chk("con_blocked_by_wbu", {28'h0, con_busy}, 32'hF);
        @(negedge clk);
        wbu_tx_stb = 1'b0;
        #1;
        chk("con_after_wbu", {28'h0, con_busy}, 32'hE);
        @(negedge clk);
        con_stb[0] = 1'b0;
        repeat (3) @(negedge clk);
        eq = '{8'hA3, 8'h41};
        chk_q("wbu_prio");

        con_stb[3] = 1'b1; con_data[27:21] = 7'h66;
        @(negedge clk);
        con_stb[3] = 1'b0;
        wbu_tx_stb = 1'b1; wbu_tx_data = 7'h11;
        #1;
        chk("wbu_busy_selb", {31'h0, wbu_tx_busy}, 32'h1);
        @(negedge clk);
        #1;
        chk("wbu_busy_data", {31'h0, wbu_tx_busy}, 32'h1);
        @(negedge clk);
        #1;
        chk("wbu_free_idle", {31'h0, wbu_tx_busy}, 32'h0);
        @(negedge clk);
        wbu_tx_stb = 1'b0;
        repeat (3) @(negedge clk);
        eq = '{8'h10, 8'h33, 8'h66, 8'h91};
        chk_q("no_split");

        reset_dut();
        con_stb = 4'b0101;
        con_data[6:0] = 7'h01;
        con_data[20:14] = 7'h02;
        @(negedge clk);
        #1;
        chk("ch0_keeps_grant", {28'h0, con_busy}, 32'hE);
        repeat (3) @(negedge clk);
        con_stb = 4'b0100;
        @(negedge clk);
        tx_busy = 1'b1;
        con_stb = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("tx_hold%0d", i), {23'h0, tx_stb, tx_data}, {23'h0, 1'b1, 8'h10});
            @(negedge clk);
        end
        tx_busy = 1'b0;
        repeat (4) @(negedge clk);
        eq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h32, 8'h02};
        chk_q("rr_switch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
